// File: rtl/bht_resolve_queue.sv
// rtl/bht_resolve_queue.sv - in-order resolution queue feeding BHT updates; BHT_RQ_TARG_CHECK_EN enables resolved-target checking
`ifndef BHT_IDX_WIDTH
`define BHT_IDX_WIDTH 10
`endif

package bht_rq_pkg;
    typedef enum logic [1:0] {INIT = 2'd0, PRIV = 2'd1, USER = 2'd2} domain_t;
endpackage

module bht_resolve_queue
    import bht_rq_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int IDX_W = `BHT_IDX_WIDTH,
    parameter int TAG_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             alloc_valid_i,
    output logic             alloc_ready_o,
    input  logic [IDX_W-1:0] alloc_idx_i,
    input  domain_t          alloc_domain_i,
    input  logic             alloc_pred_i,
    input  logic [31:0]      alloc_targ_i,
    output logic [TAG_W-1:0] alloc_tag_o,
    input  logic             res_valid_i,
    input  logic [TAG_W-1:0] res_tag_i,
    input  logic             res_taken_i,
    input  logic [31:0]      res_targ_i,
    input  logic             flush_i,
    output logic             upd_valid_o,
    input  logic             upd_ready_i,
    output logic [IDX_W-1:0] upd_idx_o,
    output domain_t          upd_domain_o,
    output logic             upd_taken_o,
    output logic [31:0]      upd_targ_o,
    output logic             upd_mispred_o,
    output logic [TAG_W:0]   count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             err_o
);
    localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count;
    logic [DEPTH-1:0] ent_valid, ent_res, ent_pred, ent_taken;
    logic [IDX_W-1:0] ent_idx   [DEPTH];
    domain_t          ent_dom   [DEPTH];
    logic [31:0]      ent_ptarg [DEPTH];
    logic             alloc_fire, retire_fire, res_hit, head_mis;
    logic [31:0]      head_targ;

    assign full_o        = (count == FULL_CNT);
    assign empty_o       = (count == '0);
    assign count_o       = count;
    assign alloc_tag_o   = tail;
    assign alloc_ready_o = !full_o && !flush_i;

    assign alloc_fire  = alloc_valid_i && alloc_ready_o;
    assign res_hit     = res_valid_i && !flush_i && ent_valid[res_tag_i] && !ent_res[res_tag_i];
    // A retire needs room in the output register; flush takes priority.
    assign retire_fire = !flush_i && ent_valid[head] && ent_res[head] && (!upd_valid_o || upd_ready_i);

`ifdef BHT_RQ_TARG_CHECK_EN
    logic [31:0] ent_rtarg [DEPTH];
    always_ff @(posedge clk_i) begin
        if (res_hit) ent_rtarg[res_tag_i] <= res_targ_i;
    end
    assign head_mis  = (ent_pred[head] != ent_taken[head]) ||
                       (ent_taken[head] && (ent_ptarg[head] != ent_rtarg[head]));
    assign head_targ = ent_rtarg[head];
`else
    logic unused_res_targ;
    assign unused_res_targ = ^res_targ_i;
    assign head_mis  = (ent_pred[head] != ent_taken[head]);
    assign head_targ = ent_ptarg[head];
`endif

    // Payload needs no reset: it is only read while the matching valid bit is set.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            ent_idx[tail]   <= alloc_idx_i;
            ent_dom[tail]   <= alloc_domain_i;
            ent_pred[tail]  <= alloc_pred_i;
            ent_ptarg[tail] <= alloc_targ_i;
        end
        if (res_hit) ent_taken[res_tag_i] <= res_taken_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            ent_valid     <= '0;
            ent_res       <= '0;
            err_o         <= 1'b0;
            upd_valid_o   <= 1'b0;
            upd_idx_o     <= '0;
            upd_domain_o  <= INIT;
            upd_taken_o   <= 1'b0;
            upd_targ_o    <= '0;
            upd_mispred_o <= 1'b0;
        end else begin
            if (flush_i) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                ent_valid <= '0;
                ent_res   <= '0;
            end else begin
                if (alloc_fire) begin
                    ent_valid[tail] <= 1'b1;
                    ent_res[tail]   <= 1'b0;
                    tail            <= tail + TAG_W'(1);
                end
                if (res_valid_i) begin
                    if (res_hit) ent_res[res_tag_i] <= 1'b1;
                    else         err_o              <= 1'b1;
                end
                if (retire_fire) begin
                    ent_valid[head] <= 1'b0;
                    head            <= head + TAG_W'(1);
                end
                count <= count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire_fire);
            end
            // The output register survives a flush: its contents are already resolved.
            if (retire_fire) begin
                upd_valid_o   <= 1'b1;
                upd_idx_o     <= ent_idx[head];
                upd_domain_o  <= ent_dom[head];
                upd_taken_o   <= ent_taken[head];
                upd_targ_o    <= head_targ;
                upd_mispred_o <= head_mis;
            end else if (upd_ready_i) begin
                upd_valid_o <= 1'b0;
            end
        end
    end
endmodule
